// File: rtl/regfile_flush_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// regfile_flush_ctrl_pkg
// Shared constants and types for the rename flush controller:
//   REGISTER_WIDTH - architectural register index width
//   ROB_WIDTH      - ROB tag width carried with each rename
//   NULL_IDX       - register x0, never renamed or cleared by the walk
//   flush_state_e  - FSM encodings FLUSH_IDLE / FLUSH_WALK / FLUSH_DONE
// ---------------------------------------------------------------------------
package regfile_flush_ctrl_pkg;

  localparam int REGISTER_WIDTH = 5;
  localparam int ROB_WIDTH      = 4;
  localparam int NUM_REGS_DEF   = 32;

  localparam logic [REGISTER_WIDTH-1:0] NULL_IDX = '0;

  typedef enum logic [1:0] {
    FLUSH_IDLE = 2'd0,
    FLUSH_WALK = 2'd1,
    FLUSH_DONE = 2'd2
  } flush_state_e;

endpackage

// File: rtl/regfile_flush_ctrl_if.sv
// ---------------------------------------------------------------------------
// regfile_flush_ctrl_if
// Bundles the ROB flush pulse, the dispatcher rename request and the
// register-file write/clear ports around the flush controller.
//   master : the controller (consumes flush/dispatcher, drives reg_* / stall)
//   slave  : the surrounding pipeline (drives flush/dispatcher, sees reg_*)
//
// Handshake: dispatcher_en_in is "valid", !dispatcher_stall_out is "ready".
// A rename is consumed in a cycle where valid && ready && rdy_in; while
// stall is high the dispatcher holds its request unchanged.
// ---------------------------------------------------------------------------
interface regfile_flush_ctrl_if #(
  parameter int IDX_W = 5,
  parameter int ROB_W = 4
);

  logic             flush_in;
  logic             dispatcher_en_in;
  logic [IDX_W-1:0] dispatcher_rd_in;
  logic [ROB_W-1:0] dispatcher_rd_dest_in;
  logic             dispatcher_stall_out;
  logic             reg_en_out;
  logic [IDX_W-1:0] reg_rd_out;
  logic [ROB_W-1:0] reg_rd_dest_out;
  logic             reg_clr_en_out;
  logic [IDX_W-1:0] reg_clr_idx_out;
  logic             flush_done_out;

  modport master (
    input  flush_in, dispatcher_en_in, dispatcher_rd_in, dispatcher_rd_dest_in,
    output dispatcher_stall_out, reg_en_out, reg_rd_out, reg_rd_dest_out,
    output reg_clr_en_out, reg_clr_idx_out, flush_done_out
  );

  modport slave (
    output flush_in, dispatcher_en_in, dispatcher_rd_in, dispatcher_rd_dest_in,
    input  dispatcher_stall_out, reg_en_out, reg_rd_out, reg_rd_dest_out,
    input  reg_clr_en_out, reg_clr_idx_out, flush_done_out
  );

endinterface

// File: rtl/regfile_clr_walker.sv
// ---------------------------------------------------------------------------
// regfile_clr_walker
// Walk counter for rename recovery: holds the register index being cleared,
// produces the clear strobe and flags the final index of the walk.
//   clk_i, rst_i  : clock, synchronous active-high reset (counter -> 1)
//   rdy_i         : global ready; low freezes the counter and hides the strobe
//   flush_i       : flush pulse; (re)loads the counter with 1
//   walk_i        : controller is in its WALK state
//   clr_en_o      : clear strobe toward the register file
//   clr_idx_o     : index being cleared (0 outside the walk)
//   last_o        : current index is the final one of the walk
// Build option: FLUSH_BULK_EN makes the walk a single "clear all" cycle
// on index 0.
// ---------------------------------------------------------------------------
module regfile_clr_walker #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rdy_i,
  input  logic             flush_i,
  input  logic             walk_i,
  output logic             clr_en_o,
  output logic [IDX_W-1:0] clr_idx_o,
  output logic             last_o
);

  logic [IDX_W-1:0] cnt_q;
  logic             start;
  logic             adv;

  assign start = rdy_i && flush_i;
  // Counter parks on the last index instead of wrapping, so index 0 is
  // never reached by the walk.
  assign adv   = rdy_i && walk_i && !flush_i && !last_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= IDX_W'(1);
    end else if (start) begin
      cnt_q <= IDX_W'(1);
    end else if (adv) begin
      cnt_q <= cnt_q + IDX_W'(1);
    end
  end

  assign clr_en_o = walk_i && rdy_i;

`ifdef FLUSH_BULK_EN
  // Index 0 with the strobe is the register file's "clear all" command;
  // the counter sits at 1 after the load, so the walk is one cycle long.
  assign last_o    = (cnt_q == IDX_W'(1));
  assign clr_idx_o = '0;
`else
  assign last_o    = (cnt_q == IDX_W'(NUM_REGS - 1));
  assign clr_idx_o = walk_i ? cnt_q : '0;
`endif

endmodule

// File: rtl/regfile_flush_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_flush_ctrl
// Sits between dispatcher, ROB and the renaming register file. Forwards
// rename writes with zero latency; on a ROB flush it stalls the dispatcher,
// walks the register file's clear port over x1..x(NUM_REGS-1) and pulses
// flush_done_out once recovery is complete.
//   clk_in      : clock
//   rst_in      : synchronous active-high reset (FSM -> IDLE)
//   rdy_in      : global ready; low holds all state and zeroes all strobes
//   bus         : regfile_flush_ctrl_if.master (flush, dispatcher, reg_*)
//   dbg_state_o : current FSM state for observation
// Build option: FLUSH_BULK_EN replaces the walk with one "clear all" cycle.
// The clear port is separate from the ROB commit port; when both target the
// same register in one cycle the register file lets the clear win.
// ---------------------------------------------------------------------------
module regfile_flush_ctrl
  import regfile_flush_ctrl_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int IDX_W    = REGISTER_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  regfile_flush_ctrl_if.master bus,
  output flush_state_e         dbg_state_o
);

  flush_state_e     state_q;
  logic             walk_last;
  logic             walk_clr_en;
  logic [IDX_W-1:0] walk_clr_idx;
  logic             stall;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= FLUSH_IDLE;
    end else if (rdy_in) begin
      case (state_q)
        FLUSH_IDLE: if (bus.flush_in) state_q <= FLUSH_WALK;
        FLUSH_WALK: begin
          // A new flush restarts the walk; the walker reloads index 1.
          if (bus.flush_in)   state_q <= FLUSH_WALK;
          else if (walk_last) state_q <= FLUSH_DONE;
        end
        FLUSH_DONE: state_q <= bus.flush_in ? FLUSH_WALK : FLUSH_IDLE;
        default:    state_q <= FLUSH_IDLE;
      endcase
    end
  end

  regfile_clr_walker #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_walker (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .rdy_i     (rdy_in),
    .flush_i   (bus.flush_in),
    .walk_i    (state_q == FLUSH_WALK),
    .clr_en_o  (walk_clr_en),
    .clr_idx_o (walk_clr_idx),
    .last_o    (walk_last)
  );

  // Stall covers the flush cycle itself so a rename racing the flush,
  // which belongs to the squashed path, is dropped.
  assign stall = bus.flush_in || (state_q != FLUSH_IDLE);

  assign bus.dispatcher_stall_out = stall;
  assign bus.reg_en_out      = rdy_in && bus.dispatcher_en_in && !stall &&
                               (bus.dispatcher_rd_in != NULL_IDX);
  assign bus.reg_rd_out      = bus.dispatcher_rd_in;
  assign bus.reg_rd_dest_out = bus.dispatcher_rd_dest_in;
  assign bus.reg_clr_en_out  = walk_clr_en;
  assign bus.reg_clr_idx_out = walk_clr_idx;
  assign bus.flush_done_out  = rdy_in && (state_q == FLUSH_DONE);

  assign dbg_state_o = state_q;

endmodule
